// File: rtl/multdiv_ctrl_if.sv
// multdiv_ctrl_if: request, unit handshake and HI/LO bus between the control unit, mult/div units and multdiv_ctrl
// master: control unit plus multiplier/divider stubs (drive requests, unit done and results)
// slave: multdiv_ctrl (drives unit pulses, latched operands, HI/LO, status pulses)
interface multdiv_ctrl_if #(parameter int DATA_W = 32);
  logic start;
  logic [1:0] op;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic unit_clr, mult_start, div_start;
  logic [DATA_W-1:0] op_a, op_b;
  logic mult_done, div_done;
  logic [DATA_W-1:0] unit_hi, unit_lo;
  logic [DATA_W-1:0] hi, lo;
  logic busy, done, div_zero, timeout;
  modport master (
    output start, op, rs_val, rt_val, mult_done, div_done, unit_hi, unit_lo,
    input unit_clr, mult_start, div_start, op_a, op_b, hi, lo, busy, done, div_zero, timeout
  );
  modport slave (
    input start, op, rs_val, rt_val, mult_done, div_done, unit_hi, unit_lo,
    output unit_clr, mult_start, div_start, op_a, op_b, hi, lo, busy, done, div_zero, timeout
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequences MULT/DIV/MTHI/MTLO onto the shared iterative units and commits HI/LO
// ports: clk, reset (sync, active-high), bus (multdiv_ctrl_if.slave)
// MULTDIV_TIMEOUT_EN: when defined, RUN aborts to ERR after TIMEOUT cycles without unit done
module multdiv_ctrl #(
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 40
) (
  input logic clk,
  input logic reset,
  multdiv_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, RUN, DONE, ERR} state_t;
  state_t state;
  logic is_div;
  logic [CNT_W-1:0] cnt;
  logic sel_done, limit;
  assign sel_done = is_div ? bus.div_done : bus.mult_done;
`ifdef MULTDIV_TIMEOUT_EN
  assign limit = cnt == CNT_W'(TIMEOUT - 1);
`else
  assign limit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      is_div <= 1'b0;
      cnt <= '0;
      bus.op_a <= '0;
      bus.op_b <= '0;
      bus.hi <= '0;
      bus.lo <= '0;
      bus.unit_clr <= 1'b0;
      bus.mult_start <= 1'b0;
      bus.div_start <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.div_zero <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      bus.unit_clr <= 1'b0;
      bus.mult_start <= 1'b0;
      bus.div_start <= 1'b0;
      bus.done <= 1'b0;
      bus.div_zero <= 1'b0;
      bus.timeout <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          if (bus.op == 2'b10) bus.hi <= bus.rs_val;
          else if (bus.op == 2'b11) bus.lo <= bus.rs_val;
          else if (bus.op[0] && bus.rt_val == '0) bus.div_zero <= 1'b1;
          else begin
            bus.op_a <= bus.rs_val;
            bus.op_b <= bus.rt_val;
            is_div <= bus.op[0];
            bus.unit_clr <= 1'b1;
            bus.busy <= 1'b1;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          bus.mult_start <= !is_div;
          bus.div_start <= is_div;
          state <= LAUNCH;
        end
        LAUNCH: begin
          cnt <= '0;
          state <= RUN;
        end
        // done beats the limit when both land on the same edge
        RUN: if (sel_done) begin
          bus.hi <= bus.unit_hi;
          bus.lo <= bus.unit_lo;
          bus.done <= 1'b1;
          state <= DONE;
        end else if (limit) begin
          bus.timeout <= 1'b1;
          state <= ERR;
        end else if (!(&cnt)) cnt <= cnt + 1'b1;
        DONE, ERR: begin
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: directed stimulus with an event-timestamp model checked every cycle
module tb_multdiv_ctrl;
  localparam int W = 32;
  localparam int TO = 40;
  localparam int BIG = 1 << 30;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int passed = 0;
  int total = 0;
  int t0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  multdiv_ctrl_if #(.DATA_W(W)) bus ();
  multdiv_ctrl #(.DATA_W(W), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cycle %0d: got %h expected %h", n, cyc, act, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) step();
  endtask

  // model: an accepted MULT/DIV at cycle a implies clear at a+1, launch at a+2,
  // unit done observed from a+3; everything else follows from timestamps
  logic [31:0] m_hi = 0, m_lo = 0, m_a = 0, m_b = 0;
  bit flight = 0, m_div = 0;
  int a = 0, fin = BIG, done_c = -1, dz_c = -1, to_c = -1;

  always @(negedge clk) begin
    bit busy_e;
    busy_e = flight && cyc >= a + 1 && cyc <= fin;
    if (cyc >= 1) begin
      chk("busy", bus.busy, busy_e);
      chk("unit_clr", bus.unit_clr, flight && cyc == a + 1);
      chk("mult_start", bus.mult_start, flight && !m_div && cyc == a + 2);
      chk("div_start", bus.div_start, flight && m_div && cyc == a + 2);
      chk("done", bus.done, cyc == done_c);
      chk("div_zero", bus.div_zero, cyc == dz_c);
      chk("timeout", bus.timeout, cyc == to_c);
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
      chk("op_a", bus.op_a, m_a);
      chk("op_b", bus.op_b, m_b);
    end
    if (reset) begin
      m_hi = 0; m_lo = 0; m_a = 0; m_b = 0;
      flight = 0; fin = BIG; done_c = -1; dz_c = -1; to_c = -1;
    end else if (!busy_e && bus.start) begin
      if (bus.op == 2'b10) m_hi = bus.rs_val;
      else if (bus.op == 2'b11) m_lo = bus.rs_val;
      else if (bus.op == 2'b01 && bus.rt_val == 0) dz_c = cyc + 1;
      else begin
        flight = 1; m_div = bus.op[0]; a = cyc; fin = BIG;
        m_a = bus.rs_val; m_b = bus.rt_val;
      end
    end else if (flight) begin
      if (fin == BIG && cyc >= a + 3 && (m_div ? bus.div_done : bus.mult_done)) begin
        m_hi = bus.unit_hi; m_lo = bus.unit_lo; done_c = cyc + 1; fin = cyc + 1;
      end
`ifdef MULTDIV_TIMEOUT_EN
      else if (fin == BIG && cyc == a + 2 + TO) begin
        to_c = cyc + 1; fin = cyc + 1;
      end
`endif
      else if (cyc == fin) flight = 0;
    end
  end

  initial begin
    bus.start = 0; bus.op = 0; bus.rs_val = 0; bus.rt_val = 0;
    bus.mult_done = 0; bus.div_done = 0; bus.unit_hi = 0; bus.unit_lo = 0;
    step(3);
    reset = 0;
    chk("rst_hi", bus.hi, 0);
    chk("rst_busy", bus.busy, 0);
    // MULT 3 * -5, other unit's done must be ignored, operand changes after cycle 0 ignored
    t0 = cyc;
    bus.start = 1; bus.op = 2'b00; bus.rs_val = 3; bus.rt_val = 32'hFFFFFFFB;
    step();
    bus.start = 0; bus.op = 2'b01; bus.rs_val = 32'hDEAD; bus.rt_val = 0;
    chk("mult_clr_c1", bus.unit_clr, 1);
    chk("mult_busy_c1", bus.busy, 1);
    step();
    chk("mult_start_c2", bus.mult_start, 1);
    chk("mult_opb_c2", bus.op_b, 32'hFFFFFFFB);
    wait_to(t0 + 10);
    bus.div_done = 1; bus.unit_hi = 32'h55; bus.unit_lo = 32'h66;
    step();
    bus.div_done = 0;
    wait_to(t0 + 35);
    bus.mult_done = 1; bus.unit_hi = 32'hFFFFFFFF; bus.unit_lo = 32'hFFFFFFF1;
    step();
    bus.mult_done = 0; bus.unit_hi = 0; bus.unit_lo = 0;
    chk("mult_done_c36", bus.done, 1);
    chk("mult_busy_c36", bus.busy, 1);
    chk("mult_hi_c36", bus.hi, 32'hFFFFFFFF);
    chk("mult_lo_c36", bus.lo, 32'hFFFFFFF1);
    step();
    chk("mult_busy_c37", bus.busy, 0);
    // DIV by zero
    t0 = cyc;
    bus.start = 1; bus.op = 2'b01; bus.rs_val = 5; bus.rt_val = 0;
    step();
    bus.start = 0;
    chk("dz_c1", bus.div_zero, 1);
    chk("dz_busy_c1", bus.busy, 0);
    chk("dz_clr_c1", bus.unit_clr, 0);
    step();
    chk("dz_hi", bus.hi, 32'hFFFFFFFF);
    // DIV 100/7 with an ignored MULT request and a stray mult_done
    t0 = cyc;
    bus.start = 1; bus.op = 2'b01; bus.rs_val = 100; bus.rt_val = 7;
    step();
    bus.start = 0;
    wait_to(t0 + 5);
    bus.start = 1; bus.op = 2'b00; bus.rs_val = 9; bus.rt_val = 9;
    step();
    bus.start = 0; bus.mult_done = 1;
    step();
    bus.mult_done = 0;
    chk("div_no_mstart_c7", bus.mult_start, 0);
    wait_to(t0 + 8);
    bus.div_done = 1; bus.unit_hi = 2; bus.unit_lo = 14;
    step();
    bus.div_done = 0;
    chk("div_done_c9", bus.done, 1);
    chk("div_hi_c9", bus.hi, 2);
    chk("div_lo_c9", bus.lo, 14);
    chk("div_opa_c9", bus.op_a, 100);
    step(2);
    // MTHI then MTLO back to back
    bus.start = 1; bus.op = 2'b10; bus.rs_val = 32'h1234;
    step();
    bus.op = 2'b11; bus.rs_val = 32'hABCD;
    chk("mthi_c1", bus.hi, 32'h1234);
    chk("mthi_busy_c1", bus.busy, 0);
    step();
    bus.start = 0;
    chk("mtlo_c2", bus.lo, 32'hABCD);
    chk("mtlo_done_c2", bus.done, 0);
    // MULT aborted by reset, then a fresh MULT
    t0 = cyc;
    bus.start = 1; bus.op = 2'b00; bus.rs_val = 6; bus.rt_val = 7;
    step();
    bus.start = 0;
    wait_to(t0 + 10);
    reset = 1;
    step();
    reset = 0;
    chk("rst_hi_c11", bus.hi, 0);
    chk("rst_lo_c11", bus.lo, 0);
    chk("rst_opa_c11", bus.op_a, 0);
    chk("rst_busy_c11", bus.busy, 0);
    t0 = cyc;
    bus.start = 1; bus.op = 2'b00; bus.rs_val = 6; bus.rt_val = 7;
    step();
    bus.start = 0;
    wait_to(t0 + 4);
    bus.mult_done = 1; bus.unit_hi = 0; bus.unit_lo = 42;
    step();
    bus.mult_done = 0;
    chk("fresh_done_c5", bus.done, 1);
    chk("fresh_lo_c5", bus.lo, 42);
    step(2);
    // unit never answers
    t0 = cyc;
    bus.start = 1; bus.op = 2'b00; bus.rs_val = 2; bus.rt_val = 3;
    step();
    bus.start = 0;
`ifdef MULTDIV_TIMEOUT_EN
    wait_to(t0 + 42);
    chk("to_busy_c42", bus.busy, 1);
    chk("to_pulse_c42", bus.timeout, 0);
    step();
    chk("to_pulse_c43", bus.timeout, 1);
    chk("to_done_c43", bus.done, 0);
    step();
    chk("to_busy_c44", bus.busy, 0);
    chk("to_lo_c44", bus.lo, 42);
`else
    wait_to(t0 + 60);
    chk("stall_busy_c60", bus.busy, 1);
    chk("stall_to_c60", bus.timeout, 0);
    bus.mult_done = 1; bus.unit_hi = 1; bus.unit_lo = 2;
    step();
    bus.mult_done = 0;
    chk("stall_done_c61", bus.done, 1);
    chk("stall_lo_c61", bus.lo, 2);
`endif
    step(3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Sequencer between the multicycle control unit and the shared iterative multiplier and divider units. It accepts MULT/DIV/MTHI/MTLO requests, clears and launches the selected unit, waits for its done, and commits the result to the architectural HI/LO registers. It stalls the CPU through busy and flags divide-by-zero without launching the divider.

Parameters:
DATA_W, 32, operand/HI/LO width
TIMEOUT, 40, maximum RUN cycles before abort (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request strobe from control unit, sampled in IDLE only
op  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO
rs_val  in  DATA_W  operand A / MTHI-MTLO source
rt_val  in  DATA_W  operand B
unit_clr  out  1  one-cycle clear pulse to the selected unit
mult_start  out  1  one-cycle launch pulse to the multiplier
div_start  out  1  one-cycle launch pulse to the divider
op_a  out  DATA_W  latched operand A, held stable CLEAR..DONE
op_b  out  DATA_W  latched operand B, held stable CLEAR..DONE
mult_done  in  1  multiplier result valid
div_done  in  1  divider result valid
unit_hi  in  DATA_W  upper result word from the selected unit
unit_lo  in  DATA_W  lower result word from the selected unit
hi  out  DATA_W  architectural HI
lo  out  DATA_W  architectural LO
busy  out  1  stall request to the control unit
done  out  1  one-cycle pulse when HI/LO has been committed by MULT/DIV
div_zero  out  1  one-cycle pulse: DIV with rt_val == 0
timeout  out  1  one-cycle pulse: unit never reported done (optional feature)

Behaviour:
- Reset: synchronous, active-high, and wins over every other event. State becomes IDLE. hi, lo, op_a, op_b, and the counter are 0. unit_clr, mult_start, div_start, busy, done, div_zero, and timeout are 0.
- Reset during any state aborts the operation. HI/LO return to 0. No done is issued.
- Cycle numbering: start is sampled high in cycle 0.
- States: IDLE, CLEAR, LAUNCH, RUN, DONE, ERR. busy = 1 in every state except IDLE.
- IDLE:
  - start & op=10: hi <= rs_val at the cycle-0 edge; stays in IDLE; no done.
  - start & op=11: lo <= rs_val at the cycle-0 edge; stays in IDLE; no done.
  - start & op=01 & rt_val==0: div_zero = 1 in cycle 1; stays in IDLE; no unit activity; HI/LO unchanged.
  - start & (op=00 or op=01 with rt_val != 0): latch op_a <= rs_val, op_b <= rt_val, and the op; go to CLEAR.
- CLEAR (cycle 1): unit_clr = 1; go to LAUNCH.
- LAUNCH (cycle 2): mult_start = 1 (MULT) or div_start = 1 (DIV); counter <= 0; go to RUN.
- RUN (cycle 3 onward):
  - Only the done input of the latched op is observed; the other unit's done is ignored.
  - On the edge where it is high: hi <= unit_hi, lo <= unit_lo; go to DONE.
  - Otherwise the counter increments.
- DONE: done = 1 for exactly one cycle; busy is still 1; go to IDLE. start is accepted again from the next cycle.
- ERR: timeout = 1 for one cycle; HI/LO unchanged; go to IDLE.
- start while busy is ignored and not queued. op, rs_val, and rt_val changes after cycle 0 have no effect.
- Launch pulses are never asserted outside LAUNCH. Exactly one launch pulse per accepted MULT/DIV.
- Counter width is ceil(log2(TIMEOUT)) + 1 bits. No wrap is possible while inside RUN.

Optional Feature:
MULTDIV_TIMEOUT_EN
- Defined: RUN goes to ERR on the edge where the counter equals TIMEOUT-1 and the selected done is 0. RUN therefore lasts at most TIMEOUT cycles. If done and the limit coincide, done wins and the result is committed.
- Undefined: no counter limit; RUN waits indefinitely; ERR is unreachable; timeout is tied 0.

Test Plan:
- MULT, rs_val = 3, rt_val = 0xFFFFFFFB. Stub raises mult_done in cycle 35 with unit_hi = 0xFFFFFFFF, unit_lo = 0xFFFFFFF1.
  - unit_clr in cycle 1 and mult_start in cycle 2, single pulses; div_start stays 0.
  - busy = 1 for cycles 1–36; done in cycle 36.
  - hi = 0xFFFFFFFF and lo = 0xFFFFFFF1 from cycle 36.
- DIV, rt_val = 0.
  - div_zero = 1 in cycle 1; busy stays 0.
  - No unit_clr or div_start; HI/LO unchanged.
- DIV 100/7 in progress; second start with MULT in cycle 5.
  - Ignored: no mult_start.
  - Stub div_done with unit_hi = 2, unit_lo = 14 commits hi = 2, lo = 14.
- MTHI 0x00001234 in cycle 0, then MTLO 0x0000ABCD in cycle 1.
  - hi = 0x1234 from cycle 1 and lo = 0xABCD from cycle 2; busy and done stay 0.
- MULT started, then reset in cycle 10.
  - All outputs are 0 at cycle 11.
  - A fresh MULT afterwards completes normally.
- With MULTDIV_TIMEOUT_EN and TIMEOUT = 40, stub never asserts done.
  - RUN covers cycles 3–42; timeout = 1 in cycle 43; busy = 0 from cycle 44.
  - HI/LO unchanged; done never asserted.
